// File: rtl/dispense_ctrl_pkg.sv
// Shared definitions for the dispense sequencer: state encoding and default timing.
// seg_top tests import the same constants.
package dispense_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PUMP     = 3'd1;
  localparam logic [2:0] ST_ACK      = 3'd2;
  localparam logic [2:0] ST_COOLDOWN = 3'd3;
  localparam logic [2:0] ST_EMPTY    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_PUMP     = ST_PUMP,
    S_ACK      = ST_ACK,
    S_COOLDOWN = ST_COOLDOWN,
    S_EMPTY    = ST_EMPTY
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1250000;
  localparam int DEF_PUMP_CYCLES     = 62500000;
  localparam int DEF_ACK_CYCLES      = 4;
  localparam int DEF_GAP_CYCLES      = 25000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dispense_ctrl_sync_debounce.sv
// Two-flop synchroniser followed by a stability debouncer; dout only follows
// the synchronised input after it has differed for DEBOUNCE_CYCLES cycles.
module sync_debounce
  import dispense_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_r;
  logic          sync_r;
  logic          dout_r;
  logic [CW-1:0] cnt_r;

  // metastability synchroniser
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  // stability counter; any bounce back to dout clears it
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt_r  <= '0;
      dout_r <= 1'b0;
    end else if (sync_r == dout_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= '0;
      dout_r <= sync_r;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/dispense_ctrl.sv
// Dispense sequencer: debounced hand trigger, timed pump run, completion strobe
// to seg_top, and a tank-empty interlock that freezes dispensing and counting.
module dispense_ctrl
  import dispense_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PUMP_CYCLES     = DEF_PUMP_CYCLES,
  parameter int ACK_CYCLES      = DEF_ACK_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic RESET,
  input  logic hand_sense,
  input  logic tank_empty,
  output logic pump_en,
  output logic count2,
  output logic count_ACK2,
  output logic busy,
  output logic empty_led
);

  localparam int CW = $clog2(max3(PUMP_CYCLES, ACK_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [CW-1:0] PUMP_LAST = CW'(PUMP_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  logic          hs_db_s;
  logic          hs_db_q_r;
  logic          tank_meta_r;
  logic          tank_e_r;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hand_db (
    .clk  (clk),
    .RESET(RESET),
    .din  (hand_sense),
    .dout (hs_db_s)
  );

  // tank level synchroniser and debounced-hand history for edge detection
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      tank_meta_r <= 1'b0;
      tank_e_r    <= 1'b0;
      hs_db_q_r   <= 1'b0;
    end else begin
      tank_meta_r <= tank_empty;
      tank_e_r    <= tank_meta_r;
      hs_db_q_r   <= hs_db_s;
    end
  end

  // next-state and shared phase counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        cnt_s = '0;
        if (tank_e_r) begin
          state_s = S_EMPTY;
        end else if (hs_db_s && !hs_db_q_r) begin
          state_s = S_PUMP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PUMP: begin
        // an empty tank aborts even on the terminal cycle
        if (tank_e_r) begin
          state_s = S_EMPTY;
          cnt_s   = '0;
        end else if (cnt_r == PUMP_LAST) begin
          state_s = S_ACK;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      S_ACK: begin
        if (cnt_r == ACK_LAST) begin
          state_s = S_COOLDOWN;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (cnt_r != GAP_LAST) begin
          cnt_s = cnt_r + 1'b1;
        end else if (tank_e_r) begin
          state_s = S_EMPTY;
          cnt_s   = '0;
        end else if (!hs_db_s) begin
          state_s = S_IDLE;
          cnt_s   = '0;
        end else begin
          state_s = S_COOLDOWN;
        end
      end
      S_EMPTY: begin
        cnt_s = '0;
        if (!tank_e_r && !hs_db_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_EMPTY;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // state register and outputs decoded from the next state, so they align with it
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      pump_en    <= 1'b0;
      count2     <= 1'b0;
      count_ACK2 <= 1'b0;
      busy       <= 1'b0;
      empty_led  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pump_en    <= (state_s == S_PUMP);
      count2     <= (state_s != S_EMPTY);
      count_ACK2 <= (state_s == S_ACK);
      busy       <= (state_s == S_PUMP) || (state_s == S_COOLDOWN);
      empty_led  <= (state_s == S_EMPTY);
    end
  end

endmodule
